// File: rtl/lfo_pkg.sv
// Shared types and saturation helpers for the LFO / tone generator.
package lfo_pkg;

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    TRI    = 2'd1,
    SAW    = 2'd2,
    SQUARE = 2'd3
  } wave_e;

  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

  localparam longint LFO_MAX = sat_max(16);
  localparam longint LFO_MIN = sat_min(16);

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine ROM, half-step sampled, with a registered read port.
module sine_quarter_rom #(
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned LUT_ADDR_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [LUT_ADDR_W-1:0] addr,
  output logic [OUT_W-1:0]      data
);

  localparam int unsigned DEPTH = 2 ** LUT_ADDR_W;

  function automatic logic [OUT_W-1:0] rom_entry(input int unsigned k);
    real full;
    real ang;
    full = real'((longint'(1) << (OUT_W - 1)) - 1);
    ang  = 1.5707963267948966 * (real'(k) + 0.5) / real'(DEPTH);
    return OUT_W'($rtoi(full * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-1:0] rom_tbl [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom_tbl[k] = rom_entry(k);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) data <= '0;
    else        data <= rom_tbl[addr];
  end

endmodule

// File: rtl/lfo_generator.sv
// Phase-accumulator NCO: sine/triangle/saw/square with amplitude scaling.
// Optional phase-reset input `sync` is present when LFO_SYNC_EN is defined.
module lfo_generator
  import lfo_pkg::*;
#(
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned PHASE_W    = 24,
  parameter int unsigned LUT_ADDR_W = 8,
  parameter int unsigned AMP_W      = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    tick,
  input  logic [PHASE_W-1:0]      phase_inc,
  input  wave_e                   mode,
  input  logic [AMP_W-1:0]        amp,
`ifdef LFO_SYNC_EN
  input  logic                    sync,
`endif
  output logic signed [OUT_W-1:0] sample,
  output logic                    sample_valid
);

  // Only the top OUT_W+1 phase bits ever reach the waveform logic.
  localparam int unsigned TOP_W  = OUT_W + 1;
  localparam int unsigned PROD_W = OUT_W + AMP_W + 1;
  localparam logic signed [OUT_W-1:0]  SMAX = OUT_W'(sat_max(OUT_W));
  localparam logic signed [OUT_W-1:0]  SMIN = OUT_W'(sat_min(OUT_W));
  localparam logic signed [PROD_W-1:0] PMAX = PROD_W'(sat_max(OUT_W));
  localparam logic signed [PROD_W-1:0] PMIN = PROD_W'(sat_min(OUT_W));

  logic               zero_phase;
  logic [PHASE_W-1:0] acc_q, p_sel;

`ifdef LFO_SYNC_EN
  assign zero_phase = sync;
`else
  assign zero_phase = 1'b0;
`endif
  assign p_sel = zero_phase ? '0 : acc_q;

  // Capture stage: parameters and pre-increment phase travel with the sample.
  logic             c_valid_q;
  logic [TOP_W-1:0] c_phase_q;
  wave_e            c_mode_q;
  logic [AMP_W-1:0] c_amp_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q     <= '0;
      c_valid_q <= 1'b0;
      c_phase_q <= '0;
      c_mode_q  <= SINE;
      c_amp_q   <= '0;
    end else begin
      c_valid_q <= tick;
      if (tick) begin
        c_phase_q <= p_sel[PHASE_W-1 -: TOP_W];
        c_mode_q  <= mode;
        c_amp_q   <= amp;
        acc_q     <= p_sel + phase_inc;
      end else if (zero_phase) begin
        acc_q <= '0;
      end
    end
  end

  // S1: quadrant decode and ROM read (index mirrored in quadrants 1 and 3).
  logic [LUT_ADDR_W-1:0] rom_idx, rom_addr;
  logic [OUT_W-1:0]      rom_data;

  assign rom_idx  = c_phase_q[TOP_W-3 -: LUT_ADDR_W];
  assign rom_addr = c_phase_q[TOP_W-2] ? ~rom_idx : rom_idx;

  sine_quarter_rom #(
    .OUT_W      (OUT_W),
    .LUT_ADDR_W (LUT_ADDR_W)
  ) u_rom (
    .CLK  (CLK),
    .RST_N(RST_N),
    .addr (rom_addr),
    .data (rom_data)
  );

  logic             s1_valid_q;
  logic [TOP_W-1:0] s1_phase_q;
  wave_e            s1_mode_q;
  logic [AMP_W-1:0] s1_amp_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q <= 1'b0;
      s1_phase_q <= '0;
      s1_mode_q  <= SINE;
      s1_amp_q   <= '0;
    end else begin
      s1_valid_q <= c_valid_q;
      s1_phase_q <= c_phase_q;
      s1_mode_q  <= c_mode_q;
      s1_amp_q   <= c_amp_q;
    end
  end

  // S2: sign/mirror and waveform select.
  logic                    msb;
  logic [OUT_W-1:0]        tri_t;
  logic signed [OUT_W-1:0] wave;

  assign msb = s1_phase_q[TOP_W-1];

  always_comb begin
    wave  = '0;
    tri_t = s1_phase_q[TOP_W-2 -: OUT_W];
    unique case (s1_mode_q)
      SINE:   wave = msb ? -$signed(rom_data) : $signed(rom_data);
      TRI: begin
        if (msb) tri_t = ~tri_t;
        wave = {~tri_t[OUT_W-1], tri_t[OUT_W-2:0]};
      end
      SAW:    wave = {~msb, s1_phase_q[TOP_W-2 -: OUT_W-1]};
      SQUARE: wave = msb ? -SMAX : SMAX;
    endcase
  end

  logic                    s2_valid_q;
  logic signed [OUT_W-1:0] s2_wave_q;
  logic [AMP_W-1:0]        s2_amp_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_valid_q <= 1'b0;
      s2_wave_q  <= '0;
      s2_amp_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_wave_q  <= wave;
      s2_amp_q   <= s1_amp_q;
    end
  end

  // S3: signed x unsigned multiply, floor shift, saturate.
  logic signed [PROD_W-1:0] prod, shifted;
  logic signed [OUT_W-1:0]  sat_out;

  assign prod = $signed({{(AMP_W + 1){s2_wave_q[OUT_W-1]}}, s2_wave_q})
              * $signed({{(OUT_W + 1){1'b0}}, s2_amp_q});
  assign shifted = prod >>> (AMP_W - 1);

  always_comb begin
    if (shifted > PMAX)      sat_out = SMAX;
    else if (shifted < PMIN) sat_out = SMIN;
    else                     sat_out = shifted[OUT_W-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= s2_valid_q;
      if (s2_valid_q) sample <= sat_out;
    end
  end

endmodule

// File: tb/tb_lfo_generator.sv
// Self-checking bench for lfo_generator against a behavioural waveform model.
module tb_lfo_generator;
  import lfo_pkg::*;

`ifdef LFO_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic               CLK = 1'b0;
  logic               RST_N = 1'b1;
  logic               tick = 1'b0;
  logic [23:0]        phase_inc = '0;
  wave_e              mode = SINE;
  logic [15:0]        amp = '0;
`ifdef LFO_SYNC_EN
  logic               sync = 1'b0;
`endif
  logic signed [15:0] sample;
  logic               sample_valid;

  lfo_generator dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .tick        (tick),
    .phase_inc   (phase_inc),
    .mode        (mode),
    .amp         (amp),
`ifdef LFO_SYNC_EN
    .sync        (sync),
`endif
    .sample      (sample),
    .sample_valid(sample_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t        exp_q[$];
  int          edge_cnt = 0;
  int          exp_last = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  int unsigned model_acc = 0;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, req);
    end
  endtask

  // Model: waveforms straight from the arithmetic definitions.
  function automatic int model_rom(input int k);
    real v;
    v = 32767.0 * $sin(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / 256.0);
    return $rtoi(v + 0.5);
  endfunction

  function automatic int model_wave(input int m, input int unsigned p);
    int q, i, t;
    case (m)
      0: begin
        q = int'(p >> 22);
        i = int'((p >> 14) & 255);
        if (q % 2 == 1) i = 255 - i;
        return (q >= 2) ? -model_rom(i) : model_rom(i);
      end
      1: begin
        t = int'((p >> 7) & 65535);
        if (p >= (1 << 23)) t = 65535 - t;
        return t - 32768;
      end
      2: return int'(p >> 8) - 32768;
      default: return (p < (1 << 23)) ? 32767 : -32767;
    endcase
  endfunction

  function automatic int model_sample(input int m, input int unsigned p, input int a);
    longint prod, q;
    prod = longint'(model_wave(m, p)) * longint'(a);
    q = prod / 32768;
    if (prod < 0 && (prod % 32768) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  // One cycle of stimulus, applied just after a rising edge.
  task automatic drive(input bit t, input int unsigned inc, input int m, input int a,
                       input bit s);
    int unsigned p;
    bit se;
    se = s & SYNC_ON;
    tick      = t;
    phase_inc = inc[23:0];
    mode      = wave_e'(m[1:0]);
    amp       = a[15:0];
`ifdef LFO_SYNC_EN
    sync = s;
`endif
    if (RST_N) begin
      if (t) begin
        p = se ? 0 : model_acc;
        model_acc = (p + (inc & 32'hFF_FFFF)) & 32'hFF_FFFF;
        exp_q.push_back('{due: edge_cnt + 4, val: model_sample(m & 3, p, a & 65535)});
      end else if (se) begin
        model_acc = 0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, $urandom, int'($urandom_range(0, 3)), int'($urandom), 1'b0);
  endtask

  task automatic do_reset(input int n);
    RST_N = 1'b0;
    model_acc = 0;
    repeat (n) drive(1'b1, $urandom, int'($urandom_range(0, 3)), int'($urandom), 1'b0);
    RST_N = 1'b1;
  endtask

  // Compare process: every cycle, valid strobe and held sample value.
  initial begin
    bit exp_v;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        exp_q.delete();
        exp_last = 0;
      end
      exp_v = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
        exp_v    = 1'b1;
        exp_last = exp_q[0].val;
        void'(exp_q.pop_front());
      end
      check("sample_valid", int'(sample_valid), int'(exp_v));
      check("sample", int'(sample), exp_last);
    end
  end

  initial begin
    // Pin the model to hand-computed values.
    check("model rom0", model_rom(0), 101);
    check("model rom255 >= 32766", int'(model_rom(255) >= 32766), 1);
    check("model saw p0", model_sample(2, 0, 32768), -32768);
    check("model saw p1", model_sample(2, 1 << 21, 32768), -24576);
    check("model tri quarter", model_sample(1, 1 << 22, 32768), 0);
    check("model tri half", model_sample(1, 1 << 23, 32768), 32767);
    check("model sq sat neg", model_sample(3, 1 << 23, 65535), -32768);
    check("model sq sat pos", model_sample(3, 0, 65535), 32767);
    check("model sq half pos", model_sample(3, 0, 16384), 16383);
    check("model sq half neg", model_sample(3, 1 << 23, 16384), -16384);

    #1;
    do_reset(4);

    // Square with gaps between ticks.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1 << 22, 3, 32768, 1'b0);
      idle(i % 3);
    end
    idle(5);

    do_reset(2);
    for (int i = 0; i < 9; i++) drive(1'b1, 1 << 21, 2, 32768, 1'b0);
    idle(5);

    do_reset(2);
    for (int i = 0; i < 4; i++) drive(1'b1, 1 << 22, 0, 32768, 1'b0);
    idle(5);

    do_reset(2);
    drive(1'b1, 1 << 23, 3, 65535, 1'b0);
    drive(1'b1, 1 << 23, 3, 65535, 1'b0);
    drive(1'b1, 1 << 23, 3, 16384, 1'b0);
    drive(1'b1, 1 << 23, 3, 16384, 1'b0);
    drive(1'b1, 1 << 23, 3, 0, 1'b0);
    drive(1'b1, 1 << 23, 3, 0, 1'b0);
    idle(5);

    // Back-to-back ticks with mode changing, then reset with samples in flight.
    do_reset(2);
    for (int m = 0; m < 4; m++) drive(1'b1, $urandom, m, int'($urandom), 1'b0);
    idle(5);
    for (int m = 0; m < 4; m++) drive(1'b1, $urandom, 3 - m, int'($urandom), 1'b0);
    do_reset(2);
    idle(6);

    // phase_inc = 0 repeats a constant sample.
    for (int i = 0; i < 3; i++) drive(1'b1, 0, 1, 20000, 1'b0);
    idle(4);

`ifdef LFO_SYNC_EN
    for (int i = 0; i < 3; i++) drive(1'b1, 1 << 22, 2, 32768, 1'b0);
    drive(1'b1, 1 << 22, 2, 32768, 1'b1);
    drive(1'b0, 1 << 22, 2, 32768, 1'b1);
    drive(1'b1, 1 << 22, 2, 32768, 1'b0);
    idle(5);
`endif

    do_reset(1);
    repeat (400) begin
      drive(bit'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
            int'($urandom), ($urandom_range(0, 7) == 0));
    end
    idle(6);
    check("queue drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lfo_generator.md
# lfo_generator

Parametrised low-frequency/audio-rate oscillator for the effects chain: a phase-accumulator NCO driven by the audio sample tick, producing sine, triangle, saw or square at a programmable frequency and amplitude. Replaces fixed-table, fixed-divider tone generation. Feeds modulation inputs (tremolo, vibrato, chorus) or the mixer as a test tone.

## Interface
- `OUT_W`, 16: signed output sample width.
- `PHASE_W`, 24: phase accumulator width; one waveform period = 2^PHASE_W.
- `LUT_ADDR_W`, 8: quarter-wave sine ROM address width (2^LUT_ADDR_W entries).
- `AMP_W`, 16: amplitude width, unsigned Q1.(AMP_W-1); 2^(AMP_W-1) = unity.
- `CLK`, input, 1: system clock.
- `RST_N`, input, 1: asynchronous active-low reset.
- `tick`, input, 1: one-cycle sample strobe.
- `phase_inc`, input, PHASE_W: frequency tuning word; f = f_tick·phase_inc/2^PHASE_W.
- `mode`, input, 2: waveform select: 0 sine, 1 triangle, 2 saw, 3 square.
- `amp`, input, AMP_W: amplitude.
- `sample`, output, OUT_W signed: generated sample.
- `sample_valid`, output, 1: one-cycle strobe qualifying `sample`.

## Operation
- On a tick cycle, capture `phase_inc`, `mode`, `amp` and the current accumulator value P; accumulator <= P + phase_inc, modulo 2^PHASE_W. The sample is computed from P (pre-increment), so the first sample after reset uses phase 0.
- MAX = 2^(OUT_W-1)-1. Quadrant q = P[PHASE_W-1:PHASE_W-2]; index i = P[PHASE_W-3 -: LUT_ADDR_W]; i is bit-inverted for q = 1 and q = 3.
- Sine: ROM[k] = round(MAX·sin(π/2·(k+0.5)/2^LUT_ADDR_W)); output +ROM for q = 0,1 and −ROM for q = 2,3.
- Triangle: t = P[PHASE_W-2 -: OUT_W], inverted when P[MSB] = 1; output = t with its MSB flipped.
- Saw: {~P[MSB], P[PHASE_W-2 -: OUT_W-1]}; phase 0 gives −2^(OUT_W-1), then rises.
- Square: +MAX when P[MSB] = 0, −MAX otherwise.
- Amplitude: product = wave·amp (signed × unsigned); shift arithmetically right by AMP_W-1 (floor); saturate to [−2^(OUT_W-1), MAX].
- Parameters captured with a tick travel with that sample. Input changes on non-tick cycles have no effect on in-flight samples.
- Reset mid-operation: all pipeline valids, accumulator and `sample` clear immediately. In-flight samples are discarded and never emitted.

## Timing
- Reset values: `sample` = 0, `sample_valid` = 0, accumulator = 0, all stage registers 0.
- Pipeline has 3 stages: S1 (quadrant/index decode and registered ROM read), S2 (sign/mirror and waveform mux), S3 (multiply, shift, saturate, output register).
- Latency: a tick sampled at edge k gives `sample_valid` = 1 in the cycle after edge k+3, for exactly one cycle. `sample` holds its value until the next valid.
- Fully pipelined: ticks on consecutive cycles produce valids on consecutive cycles, in order. No back-pressure.
- Wrap-around is silent modular arithmetic. phase_inc = 0 produces a constant sample every tick.

## Configuration
- `LFO_SYNC_EN` defined: adds input port `sync` (1 bit).
  - `sync` with `tick` in the same cycle: P is forced to 0 for that sample, and accumulator <= phase_inc.
  - `sync` without `tick`: accumulator <= 0; no sample is emitted.
- `LFO_SYNC_EN` undefined: the port is absent; the phase runs freely.

## Structure
- Package `lfo_pkg`: `wave_e` enum (SINE, TRI, SAW, SQUARE) and MAX/MIN saturation helper constants. `mode` is typed as `wave_e`.
- Sub-module `sine_quarter_rom`: parametrised on OUT_W and LUT_ADDR_W; synchronous read; contents generated at elaboration time.

## Test plan
All scenarios use defaults (OUT_W=16, PHASE_W=24, AMP_W=16).
- Reset: hold RST_N low, pulse tick → `sample` = 0 and `sample_valid` = 0 throughout. Release reset and tick once → first valid appears 3 cycles later.
- Square, phase_inc = 2^22, amp = 32768, 8 ticks → 32767, 32767, −32767, −32767, repeating. Each valid arrives exactly 3 cycles after its tick.
- Saw, phase_inc = 2^21, amp = 32768 → −32768, −24576, −16384, −8192, 0, 8192, 16384, 24576, then wraps to −32768.
- Sine, phase_inc = 2^22, amp = 32768 → ROM[0], ROM[255], −ROM[0], −ROM[255], with ROM[255] ≥ 32766.
- Amplitude, square mode:
  - amp = 65535 → +32767 and −32768 (saturated).
  - amp = 16384 → +16383 and −16384.
  - amp = 0 → 0.
- Pipeline behaviour:
  - Ticks on 4 consecutive cycles while `mode` changes each cycle → 4 consecutive valids, each using its own captured mode.
  - Assert RST_N low with samples in flight → valid drops immediately and none of those samples emerge.
  - With `LFO_SYNC_EN`: assert sync with a tick mid-waveform → that sample is the phase-0 value.
